// File: rtl/comm_recv_demap.sv
// comm_recv_demap: hard-decision BPSK/QPSK demapper that packs data-subcarrier bits LSB-first
// into 32-bit words behind a 4-deep first-word-fall-through FIFO. Optional: COMM_RECV_RAW_EN.
module comm_recv_demap #(
  parameter int MODTYPE = 1,
  parameter int NSC     = 32,
  parameter int WIDTH   = 11
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    valid_x,
  input  logic                    sof_x,
  input  logic signed [WIDTH-1:0] xr,
  input  logic signed [WIDTH-1:0] xi,
  output logic                    valid_o,
  output logic [31:0]             data_o,
  input  logic                    ack_o,
  output logic                    overflow
`ifdef COMM_RECV_RAW_EN
  ,
  output logic                    valid_raw,
  output logic [5:0]              raw
`endif
);

  localparam logic [5:0] NSC_B    = 6'(NSC);
  localparam logic [4:0] POS_STEP = 5'(MODTYPE);
  localparam logic [4:0] POS_LAST = 5'(32 - MODTYPE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SKIP    = 2'd2
  } state_t;

  // Zero counts as the positive constellation point.
  function automatic logic hard_dec(input logic signed [WIDTH-1:0] v);
    return (v >= 0);
  endfunction

  state_t      state;
  logic [5:0]  bin_q;
  logic [5:0]  bin_cur;
  logic        b_re;
  logic        b_im;
  logic        dec_en;
  logic        word_done;
  logic [4:0]  pos_q;
  logic [31:0] sr_q;
  logic [31:0] sr_next;
  logic [31:0] word_p1;
  logic        vld_p1;

  logic [31:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  cnt;
  logic        push;
  logic        pop;
  logic        full;
  logic        push_ok;
  logic        drop;

  // Stage p0: bin tracking, decision and packer input (combinational on the beat).
  always_comb begin
    bin_cur   = sof_x ? 6'd0 : bin_q + 6'd1;
    b_re      = hard_dec(xr);
    b_im      = hard_dec(xi);
    dec_en    = valid_x && !sof_x && (state == COLLECT) &&
                (bin_cur != 6'd0) && (bin_cur <= NSC_B);
    word_done = dec_en && (pos_q == POS_LAST);
    sr_next   = (MODTYPE == 2) ? {b_im, b_re, sr_q[31:2]} : {b_re, sr_q[31:1]};
  end

  // FIFO side: head falls through, a full FIFO accepts a push only alongside a pop.
  always_comb begin
    full    = (cnt == 3'd4);
    valid_o = (cnt != 3'd0);
    pop     = valid_o && ack_o;
    push    = vld_p1;
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
    data_o  = valid_o ? mem[rd_ptr] : 32'd0;
  end

`ifdef COMM_RECV_RAW_EN
  logic [5:0] raw_bits;
  always_comb begin
    raw_bits = (MODTYPE == 2) ? {4'd0, b_im, b_re} : {5'd0, b_re};
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      bin_q    <= 6'd0;
      pos_q    <= 5'd0;
      vld_p1   <= 1'b0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      cnt      <= 3'd0;
      overflow <= 1'b0;
`ifdef COMM_RECV_RAW_EN
      valid_raw <= 1'b0;
      raw       <= 6'd0;
`endif
    end else begin
      // Stage p1: completed word flagged for the FIFO write on the following edge.
      vld_p1 <= word_done;
      if (valid_x) begin
        bin_q <= bin_cur;
        case (state)
          IDLE: begin
            if (sof_x) state <= COLLECT;
          end
          COLLECT: begin
            if (sof_x) begin
              pos_q <= 5'd0;
            end else if (dec_en) begin
              pos_q <= pos_q + POS_STEP;
              if (bin_cur == NSC_B) state <= SKIP;
            end
          end
          SKIP: begin
            if (sof_x || bin_cur == 6'd0) begin
              state <= COLLECT;
              pos_q <= 5'd0;
            end
          end
          default: state <= IDLE;
        endcase
      end
      // Stage p2: FIFO bookkeeping.
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
      if (drop) overflow <= 1'b1;
`ifdef COMM_RECV_RAW_EN
      valid_raw <= dec_en;
      if (dec_en) raw <= raw_bits;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (dec_en) sr_q <= sr_next;
    if (word_done) word_p1 <= sr_next;
    if (push_ok) mem[wr_ptr] <= word_p1;
  end

endmodule
